// File: rtl/mac_pkg.sv
// Shared types and arithmetic for the time-multiplexed MAC array.
`define LANE_SLICE(v, l, w) v[(l)*(w) +: (w)]

package mac_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int SAT_W = 64;

  // Adds two sign-extended aw-bit values; returns {overflow, result} with the
  // result either clamped to the aw-bit range or wrapped modulo 2^aw.
  function automatic logic [SAT_W:0] sat_add(input logic signed [SAT_W-1:0] a,
                                             input logic signed [SAT_W-1:0] b,
                                             input int aw,
                                             input logic sat);
    logic signed [SAT_W:0] s, hi, lo;
    logic [SAT_W-1:0] r, span;
    logic o;
    s    = (SAT_W+1)'(a) + (SAT_W+1)'(b);
    hi   = ((SAT_W+1)'(1) <<< (aw - 1)) - (SAT_W+1)'(1);
    lo   = -hi - (SAT_W+1)'(1);
    span = SAT_W'(1) << aw;
    o    = (s > hi) || (s < lo);
    if (!o)
      r = s[SAT_W-1:0];
    else if (sat)
      r = (s > hi) ? hi[SAT_W-1:0] : lo[SAT_W-1:0];
    else if (s > hi)
      r = s[SAT_W-1:0] - span;
    else
      r = s[SAT_W-1:0] + span;
    return {o, r};
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: product register, NUM_ACC-deep accumulator bank, saturation
// and overflow detection, and a drain read port with same-cycle write bypass.
module mac_lane
  import mac_pkg::*;
#(
  parameter int NUM_ACC = 4,
  parameter int W       = 8,
  parameter int ACC_W   = 16,
  parameter int SAT     = 1,
  localparam int TW     = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    mul_en,
  input  logic signed [W-1:0]     x,
  input  logic signed [W-1:0]     w,
  input  logic                    add_en,
  input  logic [TW-1:0]           add_idx,
  input  logic [TW-1:0]           rd_idx,
  output logic signed [ACC_W-1:0] rd_data,
  output logic                    add_ovf
);

  logic signed [2*W-1:0]   prod_q;
  logic signed [ACC_W-1:0] acc [NUM_ACC];
  logic [SAT_W:0]          sum;
  logic signed [ACC_W-1:0] sum_acc;
  logic [SAT_W-1-ACC_W:0]  sum_unused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prod_q <= '0;
    else if (mul_en)
      prod_q <= (2*W)'(x) * (2*W)'(w);
  end

  assign sum        = sat_add(SAT_W'(acc[add_idx]), SAT_W'(prod_q), ACC_W, SAT != 0);
  assign sum_acc    = sum[ACC_W-1:0];
  assign sum_unused = sum[SAT_W-1:ACC_W];
  assign add_ovf    = add_en & sum[SAT_W];

  // Contents are don't-care across reset: every job starts with a clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
    end else if (add_en) begin
      acc[add_idx] <= sum_acc;
    end
  end

  // Bypass lets the drain load row 0 in the same cycle its final add lands.
  assign rd_data = (add_en && add_idx == rd_idx) ? sum_acc : acc[rd_idx];

endmodule

// File: rtl/mac_array_mv.sv
// y = W*x for n <= LANES*NUM_ACC using per-lane accumulator banks, one tile of
// LANES rows per pass over x; results drain row by row on a valid/ready stream.
module mac_array_mv
  import mac_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int NUM_ACC = 4,
  parameter int W       = 8,
  parameter int ACC_W   = 16,
  parameter int SAT     = 1,
  localparam int NMAX   = LANES * NUM_ACC,
  localparam int NW     = $clog2(NMAX + 1),
  localparam int RW     = (NMAX > 1) ? $clog2(NMAX) : 1,
  localparam int TW     = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1,
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NW-1:0]      n_dim,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_x,
  input  logic [LANES*W-1:0] in_w,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic [RW-1:0]      out_row,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               ovf
);

  state_t                  state, state_nx;
  logic [NW-1:0]           n_q, col;
  logic [TW-1:0]           tile, tile_last, p_tile, rd_tile;
  logic                    p_vld, err_q;
  logic [RW-1:0]           nxt_row;
  logic [LW-1:0]           rd_lane;
  logic signed [ACC_W-1:0] rd_data [LANES];
  logic [LANES-1:0]        lane_ovf;
  logic                    start_ok, in_fire, out_fire, col_last, last_beat, last_row;

  assign start_ok  = (state == S_IDLE) && start;
  assign in_ready  = (state == S_ACCUM);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign tile_last = TW'((32'(n_q) - 1) / LANES);
  assign col_last  = (col == n_q - NW'(1));
  assign last_beat = in_fire && col_last && (tile == tile_last);
  assign last_row  = (out_row == RW'(n_q - NW'(1)));
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign err       = done && err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (n_dim == '0 || n_dim > NW'(NMAX)) ? S_DONE : S_CLEAR;
      S_CLEAR: state_nx = S_ACCUM;
      S_ACCUM: if (last_beat) state_nx = S_FLUSH;
      S_FLUSH: state_nx = S_DRAIN;
      S_DRAIN: if (out_fire && last_row) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Drain read address: row 0 while flushing, otherwise the row after the one on display.
  assign nxt_row = (state == S_DRAIN) ? out_row + RW'(1) : '0;
  assign rd_tile = TW'(32'(nxt_row) / LANES);
  assign rd_lane = LW'(32'(nxt_row) % LANES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q       <= '0;
      err_q     <= 1'b0;
      ovf       <= 1'b0;
      tile      <= '0;
      col       <= '0;
      p_vld     <= 1'b0;
      p_tile    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
    end else begin
      p_vld  <= in_fire;
      p_tile <= tile;
      if (start_ok) begin
        n_q   <= n_dim;
        err_q <= (n_dim > NW'(NMAX));
      end
      if (start_ok || state == S_CLEAR) ovf <= 1'b0;
      else if (|lane_ovf)               ovf <= 1'b1;
      if (state == S_CLEAR) begin
        tile <= '0;
        col  <= '0;
      end else if (in_fire) begin
        if (col_last) begin
          col  <= '0;
          tile <= tile + TW'(1);
        end else begin
          col <= col + NW'(1);
        end
      end
      if (state == S_FLUSH) begin
        out_valid <= 1'b1;
        out_data  <= rd_data[rd_lane];
        out_row   <= '0;
      end else if (state == S_DRAIN && out_fire) begin
        if (last_row) begin
          out_valid <= 1'b0;
        end else begin
          out_row  <= nxt_row;
          out_data <= rd_data[rd_lane];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_lane #(
      .NUM_ACC(NUM_ACC),
      .W      (W),
      .ACC_W  (ACC_W),
      .SAT    (SAT)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (state == S_CLEAR),
      .mul_en (in_fire),
      .x      (in_x),
      .w      (`LANE_SLICE(in_w, l, W)),
      .add_en (p_vld),
      .add_idx(p_tile),
      .rd_idx (rd_tile),
      .rd_data(rd_data[l]),
      .add_ovf(lane_ovf[l])
    );
  end

endmodule

// File: tb/tb_mac_array_mv.sv
// Scoreboard bench: a saturating DUT and a wrapping DUT run the same jobs in lockstep.
module tb_mac_array_mv;

  localparam int LANES = 4;
  localparam int NMAX  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  n_dim = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_x = '0;
  logic [31:0] in_w = '0;
  logic        out_ready = 1'b1;

  logic        s_in_ready, s_out_valid, s_busy, s_done, s_err, s_ovf;
  logic [15:0] s_out_data;
  logic [3:0]  s_out_row;
  logic        w_in_ready, w_out_valid, w_busy, w_done, w_err, w_ovf;
  logic [15:0] w_out_data;
  logic [3:0]  w_out_row;

  mac_array_mv #(.LANES(4), .NUM_ACC(4), .W(8), .ACC_W(16), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .n_dim(n_dim),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_x(in_x), .in_w(in_w),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_row(s_out_row),
    .busy(s_busy), .done(s_done), .err(s_err), .ovf(s_ovf));

  mac_array_mv #(.LANES(4), .NUM_ACC(4), .W(8), .ACC_W(16), .SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .n_dim(n_dim),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_x(in_x), .in_w(in_w),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data), .out_row(w_out_row),
    .busy(w_busy), .done(w_done), .err(w_err), .ovf(w_ovf));

  always #5 clk = ~clk;

  typedef struct { int d; int r; } beat_t;
  beat_t q_s[$];
  beat_t q_w[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_hs = 0;
  bit rdy_rand_en = 1'b0;
  int wm [16][16];
  int xv [16];
  bit exp_ovf_s, exp_ovf_w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rdy_rand_en ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Monitor: pops expected beats on handshakes and checks hold-stability during stalls.
  logic [15:0] prev_d;
  logic [3:0]  prev_r;
  bit          prev_stall = 1'b0;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", int'(s_out_valid), 1);
        check("stall_data", int'(s_out_data), int'(prev_d));
        check("stall_row", int'(s_out_row), int'(prev_r));
      end
      if (s_out_valid && out_ready) begin
        if (q_s.size() == 0) begin
          checks++; failures++;
          $display("FAIL beat_sat: unexpected beat row %0d data %0d, none outstanding", s_out_row, $signed(s_out_data));
        end else begin
          e = q_s.pop_front();
          check("y_sat", int'($signed(s_out_data)), e.d);
          check("row_sat", int'(s_out_row), e.r);
        end
        last_hs = cyc;
      end
      if (w_out_valid && out_ready) begin
        if (q_w.size() == 0) begin
          checks++; failures++;
          $display("FAIL beat_wrap: unexpected beat row %0d data %0d, none outstanding", w_out_row, $signed(w_out_data));
        end else begin
          e = q_w.pop_front();
          check("y_wrap", int'($signed(w_out_data)), e.d);
          check("row_wrap", int'(w_out_row), e.r);
        end
      end
      prev_stall = s_out_valid && !out_ready;
      prev_d     = s_out_data;
      prev_r     = s_out_row;
    end
  end

  function automatic int wrap16(input int v);
    logic [31:0] t;
    t = v;
    return int'($signed(t[15:0]));
  endfunction

  // Reference: every lane row (including unused rows of the last tile) accumulates
  // column by column; only rows < n are expected on the output.
  task automatic build_expect(input int n);
    int t_cnt, as, aw, p;
    beat_t b;
    exp_ovf_s = 0;
    exp_ovf_w = 0;
    t_cnt = (n + LANES - 1) / LANES;
    for (int r = 0; r < t_cnt * LANES; r++) begin
      as = 0;
      aw = 0;
      for (int c = 0; c < n; c++) begin
        p  = wm[r][c] * xv[c];
        as = as + p;
        if (as > 32767)       begin as = 32767;  exp_ovf_s = 1; end
        else if (as < -32768) begin as = -32768; exp_ovf_s = 1; end
        aw = aw + p;
        if (aw > 32767 || aw < -32768) begin aw = wrap16(aw); exp_ovf_w = 1; end
      end
      if (r < n) begin
        b.r = r;
        b.d = as; q_s.push_back(b);
        b.d = aw; q_w.push_back(b);
      end
    end
  endtask

  // mode: 0 small random, 1 identity with x=c+1, 2 w=2 x=3, 3 w=x=127, 4 full-range random
  task automatic run_job(input int n, input int mode, input bit stall, input bit spur);
    int t_cnt, k;
    bit bad_n;
    logic [31:0] wv;
    bad_n = (n == 0) || (n > NMAX);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        case (mode)
          0:       wm[r][c] = $urandom_range(0, 31) - 16;
          1:       wm[r][c] = (r == c) ? 1 : 0;
          2:       wm[r][c] = 2;
          3:       wm[r][c] = 127;
          default: wm[r][c] = $urandom_range(0, 255) - 128;
        endcase
      end
      case (mode)
        0:       xv[r] = $urandom_range(0, 31) - 16;
        1:       xv[r] = r + 1;
        2:       xv[r] = 3;
        3:       xv[r] = 127;
        default: xv[r] = $urandom_range(0, 255) - 128;
      endcase
    end
    if (!bad_n) build_expect(n);
    else begin exp_ovf_s = 0; exp_ovf_w = 0; end
    rdy_rand_en = stall;

    @(posedge clk); #1;
    start = 1'b1;
    n_dim = 5'(n);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    if (bad_n) begin
      check("done_immediate", int'(s_done), 1);
      check("err_immediate", int'(s_err), (n > NMAX) ? 1 : 0);
      check("ovf_immediate", int'(s_ovf), 0);
      check("wrap_done_immediate", int'(w_done), 1);
    end else begin
      check("busy_clear", int'(s_busy), 1);
      t_cnt = (n + LANES - 1) / LANES;
      @(posedge clk); #1;
      for (int t = 0; t < t_cnt; t++) begin
        for (int c = 0; c < n; c++) begin
          if (stall) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          end
          for (int l = 0; l < LANES; l++) wv[l*8 +: 8] = 8'(wm[t*LANES + l][c]);
          in_w     = wv;
          in_x     = 8'(xv[c]);
          in_valid = 1'b1;
          if (spur && t == 0 && c == 1) begin
            start = 1'b1;
            n_dim = 5'd3;
          end
          k = 0;
          forever begin
            @(negedge clk);
            if (s_in_ready || k > 100) break;
            k++;
          end
          if (k > 100) begin
            checks++; failures++;
            $display("FAIL in_ready_timeout: in_ready stayed 0, expected 1 within 100 cycles");
          end
          @(posedge clk); #1;
          in_valid = 1'b0;
          start    = 1'b0;
          n_dim    = 5'(n);
        end
      end
      k = 0;
      do begin @(negedge clk); k++; end while (!s_done && k < 400);
      if (!s_done) begin
        checks++; failures++;
        $display("FAIL done_timeout: done stayed 0, expected 1 within 400 cycles");
      end else begin
        check("done_after_last_hs", cyc, last_hs + 1);
        check("err_job", int'(s_err), 0);
        check("ovf_sat", int'(s_ovf), int'(exp_ovf_s));
        check("ovf_wrap", int'(w_ovf), int'(exp_ovf_w));
        check("wrap_done", int'(w_done), 1);
        check("pending_sat", q_s.size(), 0);
        check("pending_wrap", q_w.size(), 0);
      end
    end
    rdy_rand_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, int'(s_in_ready), 0);
    check({tag, "_out_valid"}, int'(s_out_valid), 0);
    check({tag, "_out_data"}, int'(s_out_data), 0);
    check({tag, "_out_row"}, int'(s_out_row), 0);
    check({tag, "_busy"}, int'(s_busy), 0);
    check({tag, "_done"}, int'(s_done), 0);
    check({tag, "_err"}, int'(s_err), 0);
    check({tag, "_ovf"}, int'(s_ovf), 0);
    check({tag, "_wrap_ovf"}, int'(w_ovf), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_job(4, 1, 0, 0);   // identity
    run_job(6, 2, 0, 0);   // two tiles, rows 6..7 never output
    run_job(4, 3, 0, 0);   // saturate / wrap to -1020
    run_job(4, 4, 1, 0);   // stalls on both streams
    run_job(4, 0, 1, 1);   // stalls plus start while busy
    run_job(0, 0, 0, 0);
    run_job(17, 0, 0, 0);

    // Abort a job mid-accumulation.
    @(posedge clk); #1;
    start = 1'b1;
    n_dim = 5'd4;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_x     = 8'd100;
    in_w     = {4{8'd100}};
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    run_job(4, 1, 0, 0);

    for (int i = 0; i < 8; i++)
      run_job($urandom_range(1, 16), (i % 2 == 0) ? 0 : 4, 1'($urandom_range(0, 1)), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
